// File: rtl/lut_cfg_pkg.sv
// Shared definitions for the LUT configuration loader: FSM encoding,
// counter width helper and the image/word geometry legality check.
package lut_cfg_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t LOAD   = 2'd1;
    localparam state_t COMMIT = 2'd2;
    localparam state_t DONE   = 2'd3;

    // Counters never collapse to zero width, so single-LUT / single-word banks stay legal.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic bit geometry_ok(input int mem_size, input int cfg_width);
        return (cfg_width > 0) && (cfg_width <= mem_size) && ((mem_size % cfg_width) == 0);
    endfunction

endpackage

// File: rtl/lut_cfg_shift.sv
// Word-assembly shift register: each accepted word enters at the top, so the
// first word of an image ends up in the least significant slot.
module lut_cfg_shift
    import lut_cfg_pkg::*;
#(
    parameter int MEM_SIZE     = 16,
    parameter int CONFIG_WIDTH = 4
) (
    input  logic                    config_clk,
    input  logic                    config_rst,
    input  logic                    shift_en,
    input  logic [CONFIG_WIDTH-1:0] word_in,
    output logic [MEM_SIZE-1:0]     image_out
);

    generate
        if (MEM_SIZE == CONFIG_WIDTH) begin : g_single
            always_ff @(posedge config_clk or posedge config_rst) begin
                if (config_rst)    image_out <= '0;
                else if (shift_en) image_out <= word_in;
            end
        end else begin : g_multi
            always_ff @(posedge config_clk or posedge config_rst) begin
                if (config_rst)    image_out <= '0;
                else if (shift_en) image_out <= {word_in, image_out[MEM_SIZE-1:CONFIG_WIDTH]};
            end
        end
    endgenerate

endmodule

// File: rtl/lut_config_loader.sv
// Streams configuration words into per-LUT images and pulses each LUT's
// config enable once its image is complete, walking the whole bank once per start.
module lut_config_loader
    import lut_cfg_pkg::*;
#(
    parameter int NUM_LUTS     = 4,
    parameter int INPUTS       = 4,
    parameter int MEM_SIZE     = 16,
    parameter int CONFIG_WIDTH = 4
) (
    input  logic                    config_clk,
    input  logic                    config_rst,
    input  logic                    start,
    input  logic [CONFIG_WIDTH-1:0] cfg_word,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    output logic [MEM_SIZE-1:0]     lut_config_in,
    output logic [NUM_LUTS-1:0]     lut_config_en,
    output logic                    busy,
    output logic                    done
);

    localparam int WORDS_PER_LUT = MEM_SIZE / CONFIG_WIDTH;
    localparam int WC_W          = cnt_w(WORDS_PER_LUT);
    localparam int LI_W          = cnt_w(NUM_LUTS);
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(WORDS_PER_LUT - 1);
    localparam logic [LI_W-1:0] LAST_LUT  = LI_W'(NUM_LUTS - 1);

    generate
        if (!geometry_ok(MEM_SIZE, CONFIG_WIDTH)) begin : g_bad_geometry
            $error("lut_config_loader: MEM_SIZE must be a multiple of CONFIG_WIDTH");
        end
        if (MEM_SIZE != (1 << INPUTS)) begin : g_bad_inputs
            $error("lut_config_loader: MEM_SIZE must equal 2**INPUTS");
        end
        if (NUM_LUTS < 1) begin : g_bad_luts
            $error("lut_config_loader: NUM_LUTS must be at least 1");
        end
    endgenerate

    state_t          state;
    logic [WC_W-1:0] word_cnt;
    logic [LI_W-1:0] lut_idx;
    logic            accept;

    // Ready is a pure state decode, so there is no path from cfg_valid to cfg_ready.
    assign cfg_ready = (state == LOAD);
    assign busy      = (state == LOAD) || (state == COMMIT);
    assign done      = (state == DONE);
    assign accept    = cfg_ready && cfg_valid;

    always_ff @(posedge config_clk or posedge config_rst) begin
        if (config_rst) begin
            state    <= IDLE;
            word_cnt <= '0;
            lut_idx  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= LOAD;
                        word_cnt <= '0;
                        lut_idx  <= '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (word_cnt == LAST_WORD) begin
                            word_cnt <= '0;
                            state    <= COMMIT;
                        end else begin
                            word_cnt <= word_cnt + WC_W'(1);
                        end
                    end
                end
                COMMIT: begin
                    if (lut_idx == LAST_LUT) begin
                        state <= DONE;
                    end else begin
                        lut_idx <= lut_idx + LI_W'(1);
                        state   <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    generate
        for (genvar i = 0; i < NUM_LUTS; i++) begin : g_en
            assign lut_config_en[i] = (state == COMMIT) && (lut_idx == LI_W'(i));
        end
    endgenerate

    lut_cfg_shift #(
        .MEM_SIZE     (MEM_SIZE),
        .CONFIG_WIDTH (CONFIG_WIDTH)
    ) u_shift (
        .config_clk (config_clk),
        .config_rst (config_rst),
        .shift_en   (accept),
        .word_in    (cfg_word),
        .image_out  (lut_config_in)
    );

endmodule
